// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a frame serialiser with programmable
// baud divider, 5-8 data bits, optional parity, 1/2 stop bits and break generation.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_stop_bits_i,
    input  logic                          cfg_break_i,
    input  logic                          fifo_clr_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BRK, BRK_END
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, level;
    logic             full, empty, push, pop;
    logic [7:0]       head;

    state_t           state, state_nxt, launch_state;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt, last_idx;
    logic             bit_end, brk_release, tx_nxt, parity;

    logic [7:0]       data_r;
    logic [DIV_W-1:0] div_r;
    logic             pe_r, odd_r, stop2_r;
    logic [1:0]       bits_r;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level        = wr_ptr - rd_ptr;
    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign push         = tx_valid_i & ~full;
    assign head         = mem[rd_ptr[AW-1:0]];
    assign tx_ready_o   = ~full;
    assign fifo_level_o = level;
    assign busy_o       = (state != IDLE) | ~empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (fifo_clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !fifo_clr_i) mem[wr_ptr[AW-1:0]] <= tx_data_i;
    end

    // Frame parameters are frozen at pop so mid-frame config writes cannot corrupt it.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            data_r  <= head;
            div_r   <= cfg_div_i;
            pe_r    <= cfg_parity_en_i;
            odd_r   <= cfg_parity_odd_i;
            bits_r  <= cfg_bits_i;
            stop2_r <= cfg_stop_bits_i;
        end else if (brk_release) begin
            div_r   <= cfg_div_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            tx_o  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            tx_o  <= tx_nxt;
        end
    end

    assign bit_end  = (cnt == div_r);
    assign last_idx = 3'd4 + {1'b0, bits_r};

    // Decision taken in IDLE and on the edge ending the last stop bit; break wins over a pop.
    always_comb begin
        launch_state = IDLE;
        if (cfg_break_i)             launch_state = BRK;
        else if (!empty && cfg_en_i) launch_state = START;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE:    state_nxt = launch_state;
            START:   if (bit_end) begin
                         state_nxt = DATA;
                         idx_nxt   = '0;
                     end
            DATA:    if (bit_end) begin
                         if (idx == last_idx) state_nxt = pe_r ? PARITY : STOP1;
                         else                 idx_nxt   = idx + 3'd1;
                     end
            PARITY:  if (bit_end) state_nxt = STOP1;
            STOP1:   if (bit_end) state_nxt = stop2_r ? STOP2 : launch_state;
            STOP2:   if (bit_end) state_nxt = launch_state;
            BRK:     if (!cfg_break_i) state_nxt = BRK_END;
            BRK_END: if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        pop         = (state_nxt == START) && (state != START);
        brk_release = (state == BRK) && (state_nxt == BRK_END);

        if (state_nxt == IDLE || state_nxt == BRK) cnt_nxt = '0;
        else if (state_nxt != state || bit_end)    cnt_nxt = '0;
        else                                       cnt_nxt = cnt + DIV_W'(1);
    end

    assign parity = ^(data_r & (8'hFF >> (2'd3 - bits_r))) ^ odd_r;

    // tx_o is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_r[idx_nxt];
            PARITY:  tx_nxt = parity;
            BRK:     tx_nxt = 1'b0;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and randomised frames compared against a line
// waveform built from the frame format rules.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        cfg_parity_en, cfg_parity_odd;
    logic [1:0]  cfg_bits;
    logic        cfg_stop_bits, cfg_break, fifo_clr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, tx, busy;
    logic [3:0]  level;

    int total = 0;
    int bad   = 0;

    logic line[$];
    logic exp_line[$];
    logic rec = 1'b0;

    uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_parity_en_i(cfg_parity_en), .cfg_parity_odd_i(cfg_parity_odd),
        .cfg_bits_i(cfg_bits), .cfg_stop_bits_i(cfg_stop_bits), .cfg_break_i(cfg_break),
        .fifo_clr_i(fifo_clr), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .tx_o(tx), .busy_o(busy), .fifo_level_o(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rec) line.push_back(tx);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_const(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_line.push_back(v);
    endtask

    // One frame: start 0, n data bits LSB first, optional parity, 1 or 2 stop bits.
    task automatic add_frame(input logic [7:0] d, input int n, input int pe,
                             input int odd, input int s2, input int div);
        logic p;
        p = (odd != 0);
        add_const(1'b0, div + 1);
        for (int i = 0; i < n; i++) begin
            add_const(d[i], div + 1);
            p = p ^ d[i];
        end
        if (pe != 0) add_const(p, div + 1);
        add_const(1'b1, div + 1);
        if (s2 != 0) add_const(1'b1, div + 1);
    endtask

    task automatic compare_line(input string tag);
        logic e;
        total++;
        assert (line.size() >= exp_line.size()) else begin
            bad++;
            $error("FAIL %s_len: observed=%0d expected>=%0d", tag, line.size(), exp_line.size());
        end
        for (int i = 0; i < line.size(); i++) begin
            e = (i < exp_line.size()) ? exp_line[i] : 1'b1;
            total++;
            assert (line[i] === e) else begin
                bad++;
                $error("FAIL %s[%0d]: observed=%b expected=%b", tag, i, line[i], e);
            end
        end
        line.delete();
        exp_line.delete();
    endtask

    task automatic set_cfg(input int div, input int bits, input int pe, input int odd, input int s2);
        cfg_div        = div[15:0];
        cfg_bits       = bits[1:0];
        cfg_parity_en  = pe[0];
        cfg_parity_odd = odd[0];
        cfg_stop_bits  = s2[0];
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [7:0] d, input int div,
                              input int bits, input int pe, input int odd, input int s2);
        int len;
        len = (7 + bits + pe + s2) * (div + 1);
        set_cfg(div, bits, pe, odd, s2);
        line.delete();
        exp_line.delete();
        add_const(1'b1, 1);
        add_frame(d, 5 + bits, pe, odd, s2, div);
        rec = 1'b1;
        push(d);
        check({tag, "_lvl1"}, level, 1);
        check({tag, "_busy1"}, busy, 1);
        check({tag, "_idle_before_pop"}, tx, 1);
        repeat (len) tick();
        check({tag, "_busy_last"}, busy, 1);
        tick();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_lvl_end"}, level, 0);
        rec = 1'b0;
        compare_line(tag);
    endtask

    logic [7:0] acc[$];
    logic [7:0] pend, b1, b2;
    logic [7:0] bq[6];
    localparam int H = 30;

    initial begin
        rstn = 1'b0; cfg_en = 1'b0; cfg_break = 1'b0; fifo_clr = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_level", level, 0);
        rstn = 1'b1;
        tick();
        cfg_en = 1'b1;

        // Directed frames
        run_single("a5_8e1", 8'hA5, 3, 3, 1, 0, 0);
        run_single("1f_5o2", 8'h1F, 1, 0, 1, 1, 1);
        run_single("e0_5o2", 8'hE0, 0, 0, 1, 1, 1);
        run_single("div0_8n1", 8'h3C, 0, 3, 0, 0, 0);

        // Randomised frames
        for (int r = 0; r < 8; r++) begin
            run_single("rnd", 8'($urandom_range(0, 255)), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Fill while disabled, then drain back-to-back
        set_cfg(1, 3, 0, 0, 0);
        cfg_en = 1'b0;
        acc.delete();
        for (int i = 0; i < 9; i++) begin
            tx_data  = 8'($urandom_range(0, 255));
            tx_valid = 1'b1;
            if (acc.size() < 8) acc.push_back(tx_data);
            else                pend = tx_data;
            tick();
            check("fill_level", level, acc.size());
            check("fill_ready", tx_ready, (acc.size() < 8));
        end
        tx_valid = 1'b0;
        tick();
        check("full_level", level, 8);
        check("full_ready", tx_ready, 0);
        check("full_busy", busy, 1);
        check("full_tx_idle", tx, 1);
        line.delete();
        exp_line.delete();
        foreach (acc[i]) add_frame(acc[i], 8, 0, 0, 0, 1);
        add_frame(pend, 8, 0, 0, 0, 1);
        rec = 1'b1;
        cfg_en = 1'b1;
        tick();
        check("drain_ready", tx_ready, 1);
        check("drain_level7", level, 7);
        push(pend);
        check("drain_level8", level, 8);
        repeat (178) tick();
        check("drain_busy_last", busy, 1);
        tick();
        check("drain_busy_end", busy, 0);
        rec = 1'b0;
        compare_line("drain");

        // Break raised mid-frame with a byte queued
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        line.delete();
        exp_line.delete();
        add_const(1'b1, 1);
        add_frame(b1, 8, 0, 0, 0, 1);
        add_const(1'b0, H - 14);
        add_const(1'b1, 3);
        add_frame(b2, 8, 0, 0, 0, 1);
        rec = 1'b1;
        push(b1);
        push(b2);
        check("brk_level", level, 1);
        repeat (5) tick();
        cfg_break = 1'b1;
        repeat (19) tick();
        check("brk_hold_tx", tx, 0);
        check("brk_hold_busy", busy, 1);
        check("brk_hold_level", level, 1);
        repeat (H - 19) tick();
        cfg_break = 1'b0;
        repeat (23) tick();
        check("brk_busy_last", busy, 1);
        tick();
        check("brk_busy_end", busy, 0);
        rec = 1'b0;
        compare_line("brk");

        // Flush with level 5 during a frame, simultaneous push
        for (int i = 0; i < 6; i++) bq[i] = 8'($urandom_range(0, 255));
        line.delete();
        exp_line.delete();
        add_const(1'b1, 1);
        add_frame(bq[0], 8, 0, 0, 0, 1);
        rec = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = bq[i];
            tick();
        end
        check("clr_level5", level, 5);
        tx_data  = 8'h5A;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        tx_valid = 1'b0;
        check("clr_level0", level, 0);
        check("clr_ready", tx_ready, 1);
        repeat (14) tick();
        check("clr_busy_last", busy, 1);
        tick();
        check("clr_busy_end", busy, 0);
        repeat (6) tick();
        check("clr_quiet_busy", busy, 0);
        rec = 1'b0;
        compare_line("clr");

        // Asynchronous reset during DATA
        set_cfg(3, 3, 0, 0, 0);
        push(8'h00);
        push(8'hFF);
        repeat (6) tick();
        check("pre_rst_tx", tx, 0);
        check("pre_rst_level", level, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_level", level, 0);
        check("async_rst_ready", tx_ready, 1);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        run_single("post_rst", 8'($urandom_range(0, 255)), 2, 2, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
